fc_in_serializer: RTL
=====================

Name: fc_in_serializer

Overview:
- Reader side of the pooled flat vector produced by the max-pooling stage.
- Captures one FC_IN_VEC-element flattened vector (channel-major, element index = ch*P_SIZE*P_SIZE + pos) when the pool stage signals valid.
- Streams the vector one OF_BW element per beat to the FC layer over a valid/ready handshake, with index and last markers.
- Blocks upstream while a vector is in flight and flags any vector that is offered but cannot be accepted.

Parameters:
- CO, 3, number of pooled channels
- P_SIZE, 4, pooled feature-map side length
- OF_BW, 32, element width in bits (signed two's complement, passed unmodified)
- FC_IN_VEC, CO*P_SIZE*P_SIZE (48), elements per vector (derived; never overridden independently)

Ports:
- clk  in  1  single clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-high reset (asserted = 1, despite the name)
- i_in_valid  in  1  flat vector on i_in_vec is valid this cycle
- i_in_vec  in  FC_IN_VEC*OF_BW  flattened vector; element k at bits [k*OF_BW +: OF_BW]
- o_in_ready  out  1  block will capture i_in_vec on this edge if i_in_valid=1
- o_ot_valid  out  1  o_ot_data holds a valid element
- o_ot_data  out  OF_BW  current element
- o_ot_idx  out  clog2(FC_IN_VEC)  index of current element (0..FC_IN_VEC-1)
- o_ot_last  out  1  current element is index FC_IN_VEC-1
- i_ot_ready  in  1  FC layer accepts the element this cycle
- o_overrun  out  1  sticky: a vector was offered while o_in_ready=0

Behaviour:
- Reset (async, on reset_n=1):
  - state=IDLE; shadow vector=0; idx=0.
  - o_ot_valid=0, o_ot_data=0, o_ot_idx=0, o_ot_last=0, o_overrun=0.
  - o_in_ready=1 once reset deasserts.
- Reset mid-stream: in-flight vector is discarded, with no partial completion. The first post-reset vector starts at idx 0.
- States:
  - IDLE: o_in_ready=1, o_ot_valid=0. On i_in_valid=1: copy i_in_vec to shadow, set idx=0, go to SEND.
  - SEND: o_in_ready=0 (except with the optional feature), o_ot_valid=1. o_ot_data = shadow[idx*OF_BW +: OF_BW], registered or driven from the registered idx.
    - Beat: o_ot_valid & i_ot_ready.
    - Beat with idx<FC_IN_VEC-1: idx increments by 1.
    - Beat with idx=FC_IN_VEC-1: go to IDLE, idx returns to 0.
- Latency: vector captured at edge N; element 0 is valid in the cycle after edge N. With i_ot_ready held at 1, the vector drains in exactly FC_IN_VEC cycles.
- Stall: while i_ot_ready=0, o_ot_data, o_ot_idx and o_ot_last hold stable, and o_ot_valid stays 1. It never drops once asserted until the beat completes.
- o_ot_last = (state==SEND) && (idx==FC_IN_VEC-1).
- Overrun: i_in_valid=1 while o_in_ready=0 sets o_overrun=1. The offered vector is dropped and the shadow register is untouched. Only reset clears o_overrun.
- Upstream contract: the pool stage pulses valid for one cycle per vector. The block never back-pressures it other than by raising o_overrun.
- Data is bit-exact. There is no sign handling, saturation or reordering.

Optional Feature:
- Macro: FC_SER_BACK2BACK_EN
- Defined:
  - o_in_ready is also 1 in SEND during the last beat (o_ot_last & i_ot_ready).
  - If i_in_valid=1 in that cycle, the new vector is captured, idx returns to 0 and the state stays SEND. Element 0 of the new vector follows the last element with no bubble.
  - A vector offered in the same cycle as a non-completing last element (i_ot_ready=0) is an overrun.
- Undefined:
  - A mandatory IDLE cycle follows every vector, so the minimum vector period is FC_IN_VEC+1 cycles.
  - i_in_valid during the last beat counts as an overrun.

Test Plan:
- Reset: assert reset_n=1 for 3 cycles, release -> o_in_ready=1, o_ot_valid=0, o_overrun=0, o_ot_idx=0.
- Single vector, element k=k+1 (1..48), i_ot_ready=1 held -> element 0 appears 1 cycle after capture, then 48 consecutive beats with data 1..48 and idx 0..47. o_ot_last=1 only on data 48; o_in_ready returns to 1 the following cycle.
- Backpressure: same vector, i_ot_ready toggled 1,0,0,1 repeating -> every element delivered exactly once in order. Data/idx stable during stalls; total beats=48.
- Overrun: pulse a second vector (all 0xFFFFFFFF) at idx=10 -> o_overrun=1 and stays 1. Remaining elements 11..48 are unchanged; the second vector is never output.
- Reset mid-stream: assert reset_n at idx=20 -> o_ot_valid=0 immediately (async). After release, a new vector (element k=0x100+k) streams from idx 0 with correct data.
- FC_SER_BACK2BACK_EN defined: second vector offered on the last-beat cycle -> captured with no overrun. Its element 0 follows element 47 on the next cycle with no gap; o_overrun stays 0.
- FC_SER_BACK2BACK_EN undefined: same stimulus -> o_overrun=1 and one idle cycle after the last beat.

Source files
------------

// File: rtl/fc_in_serializer.sv
// rtl/fc_in_serializer.sv - captures the pooled flat vector and streams it one element per beat (optional: FC_SER_BACK2BACK_EN)
module fc_in_serializer #(
  parameter  int CO        = 3,
  parameter  int P_SIZE    = 4,
  parameter  int OF_BW     = 32,
  localparam int FC_IN_VEC = CO * P_SIZE * P_SIZE,
  localparam int IDX_W     = $clog2(FC_IN_VEC)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_in_valid,
  input  logic [FC_IN_VEC*OF_BW-1:0] i_in_vec,
  output logic                       o_in_ready,
  output logic                       o_ot_valid,
  output logic [OF_BW-1:0]           o_ot_data,
  output logic [IDX_W-1:0]           o_ot_idx,
  output logic                       o_ot_last,
  input  logic                       i_ot_ready,
  output logic                       o_overrun
);

  // Note: reset_n is active-high despite its name.

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FC_IN_VEC - 1);

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [FC_IN_VEC-1:0][OF_BW-1:0] r_shadow;
  logic [IDX_W-1:0]                r_idx;
  logic [IDX_W-1:0]                w_idx_nxt;
  logic                            r_overrun;
  logic                            w_capture;
  logic                            w_beat;
  logic                            w_in_ready;
  logic                            w_ot_valid;
  logic                            w_at_last;

  // Last element is being presented; it completes only on a beat.
  assign w_at_last = (r_state == S_SEND) && (r_idx == LAST_IDX);

  // State and index register; reset discards any vector in flight.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state, index advance and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_in_ready  = 1'b0;
    w_ot_valid  = 1'b0;
    w_capture   = 1'b0;
    w_beat      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (i_in_valid) begin
          w_capture   = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        w_ot_valid = 1'b1;
        w_beat     = i_ot_ready;
        if (w_beat) begin
          if (r_idx == LAST_IDX) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
`ifdef FC_SER_BACK2BACK_EN
        // A completing last beat frees the shadow, so a new vector may land
        // in the same cycle and stream on with no idle gap.
        if (w_beat && (r_idx == LAST_IDX)) begin
          w_in_ready = 1'b1;
          if (i_in_valid) begin
            w_capture   = 1'b1;
            w_state_nxt = S_SEND;
          end
        end
`endif
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Shadow copy of the vector; only a granted capture writes it.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_shadow <= '0;
    end else if (w_capture) begin
      r_shadow <= i_in_vec;
    end
  end

  // Sticky flag for a vector offered while capture was not possible.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_overrun <= 1'b0;
    end else if (i_in_valid && !w_in_ready) begin
      r_overrun <= 1'b1;
    end
  end

  assign o_in_ready = w_in_ready;
  assign o_ot_valid = w_ot_valid;
  assign o_ot_data  = w_ot_valid ? r_shadow[r_idx] : '0;
  assign o_ot_idx   = r_idx;
  assign o_ot_last  = w_at_last;
  assign o_overrun  = r_overrun;

endmodule
